// File: rtl/uart_tx_sched.sv
// uart_tx_sched: TX ring-buffer scheduler feeding uart_tx, with a one-shot 0xAA load beacon
module uart_tx_sched #(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mode,
  input  logic              push,
  input  logic [7:0]        push_data,
  output logic              push_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_waddr,
  output logic [7:0]        bram_wdata,
  output logic [ADDR_W-1:0] bram_raddr,
  input  logic [7:0]        bram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              aa_sent,
  output logic [ADDR_W-1:0] level
);
  typedef enum logic [2:0] {IDLE, BEACON, READ, LAUNCH, HOLD, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] top, bot;
  logic [2:0] cnt;
  logic beacon, empty, full, pop;
  assign empty = top == bot;
  assign full = ADDR_W'(top + 1'b1) == bot;
  assign push_ready = !full;
  assign bram_we = push && !full;
  assign bram_waddr = top;
  assign bram_wdata = push_data;
  assign level = top - bot;
  assign pop = state == IDLE && state_nx == READ;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = mode == 3'd1 && !aa_sent ? BEACON :
                          mode != 3'd1 && !empty && !tx_busy ? READ : IDLE;
      BEACON:  state_nx = LAUNCH;
      READ:    state_nx = cnt == 3'(RD_LAT + 1) ? LAUNCH : READ;
      LAUNCH:  state_nx = HOLD;
      HOLD:    state_nx = DRAIN;
      DRAIN:   state_nx = tx_busy ? DRAIN : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      top        <= '0;
      bot        <= '0;
      cnt        <= '0;
      beacon     <= 1'b0;
      bram_raddr <= '0;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      aa_sent    <= 1'b0;
    end else begin
      state    <= state_nx;
      tx_start <= state_nx == LAUNCH;
      cnt      <= state == READ ? cnt + 3'd1 : 3'd0;
      if (bram_we) top <= top + 1'b1;
      if (pop) begin
        bot        <= bot + 1'b1;
        bram_raddr <= bot;
      end
      if (state == IDLE) beacon <= state_nx == BEACON;
      if (state == IDLE && state_nx == BEACON) tx_data <= 8'hAA;
      if (state == READ && state_nx == LAUNCH) tx_data <= bram_rdata;
      if (state == DRAIN && !tx_busy && beacon) aa_sent <= 1'b1;
    end
  end
endmodule
